lsu_mem_ctrl: RTL and testbench

//  Load/store unit between the execute stage and the data-memory bus; it produces the load

---
 rtl/lsu_mem_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit between execute and the data-memory bus.
// Runs one request/grant/response bus transaction per access and stalls the
// pipeline while it is busy. Generates byte enables and lane-replicated store
// data, and aligns and extends returned load data for the writeback select.
// Build option: define MISALIGN_TRAP_EN to abort misaligned H/W accesses with
// err_o instead of silently force-aligning them.
module lsu_mem_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   input  logic        req_we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        hold_o,
   output logic        done_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   // The abort fires in the last allowed ADDR/RESP cycle.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

   state_t      state_reg;
   size_t       size_reg;
   logic        uns_reg;
   logic [1:0]  lane_reg;
   logic [15:0] tmo_cnt_reg;
   logic        we_reg;
   logic [31:0] addr_reg;
   logic [3:0]  be_reg;
   logic [31:0] wdata_reg;
   logic        mem_req_reg;
   logic        done_reg;
   logic        err_reg;
   logic [31:0] rdata_reg;

   size_t       size_next;
   logic [1:0]  lane_next;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [31:0] load_next;
   logic        tmo_hit;

   logic [7:0]  rbyte [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Decode access size; undefined funct3 codes fall back to a word access.
   always_comb begin
      case (funct3_i)
         3'b000, 3'b100: size_next = SZ_B;
         3'b001, 3'b101: size_next = SZ_H;
         default:        size_next = SZ_W;
      endcase
   end

   // Byte enables and the load lane; misaligned H/W addresses are force-aligned here.
   always_comb begin
      case (size_next)
         SZ_B: begin
            be_next   = 4'b0001 << addr_i[1:0];
            lane_next = addr_i[1:0];
         end
         SZ_H: begin
            be_next   = 4'b0011 << {addr_i[1], 1'b0};
            lane_next = {addr_i[1], 1'b0};
         end
         default: begin
            be_next   = 4'b1111;
            lane_next = 2'b00;
         end
      endcase
   end

   // Store data is replicated across all lanes so the byte enables alone pick the target.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wlane
         assign wdata_next[8*gi +: 8] = (size_next == SZ_B) ? wdata_i[7:0] :
                                        (size_next == SZ_H) ? wdata_i[8*(gi%2) +: 8] :
                                                              wdata_i[8*gi +: 8];
      end
      for (gi = 0; gi < 4; gi++) begin : g_rlane
         assign rbyte[gi] = mem_rdata_i[8*gi +: 8];
      end
   endgenerate

   assign byte_sel = rbyte[lane_reg];
   assign half_sel = lane_reg[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

   // Extract the addressed lane and sign- or zero-extend it.
   always_comb begin
      case (size_reg)
         SZ_B:    load_next = {{24{~uns_reg & byte_sel[7]}}, byte_sel};
         SZ_H:    load_next = {{16{~uns_reg & half_sel[15]}}, half_sel};
         default: load_next = mem_rdata_i;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic misalign_next;

   // Flag H accesses on odd addresses and W accesses off a word boundary.
   always_comb begin
      case (size_next)
         SZ_H:    misalign_next = addr_i[0];
         SZ_W:    misalign_next = (addr_i[1:0] != 2'b00);
         default: misalign_next = 1'b0;
      endcase
   end
`endif

   assign tmo_hit = (tmo_cnt_reg == TMO_LAST);

   // Access FSM: latches the request, walks the bus handshake, owns every registered output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         size_reg    <= SZ_B;
         uns_reg     <= 1'b0;
         lane_reg    <= 2'b00;
         tmo_cnt_reg <= 16'd0;
         we_reg      <= 1'b0;
         addr_reg    <= 32'd0;
         be_reg      <= 4'd0;
         wdata_reg   <= 32'd0;
         mem_req_reg <= 1'b0;
         done_reg    <= 1'b0;
         err_reg     <= 1'b0;
         rdata_reg   <= 32'd0;
      end else begin
         done_reg <= 1'b0;
         err_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               tmo_cnt_reg <= 16'd0;
               if (req_valid_i) begin
                  size_reg  <= size_next;
                  uns_reg   <= funct3_i[2];
                  lane_reg  <= lane_next;
                  we_reg    <= req_we_i;
                  addr_reg  <= {addr_i[31:2], 2'b00};
                  be_reg    <= be_next;
                  wdata_reg <= wdata_next;
`ifdef MISALIGN_TRAP_EN
                  if (misalign_next) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                     err_reg   <= 1'b1;
                  end else begin
                     state_reg   <= ADDR;
                     mem_req_reg <= 1'b1;
                  end
`else
                  state_reg   <= ADDR;
                  mem_req_reg <= 1'b1;
`endif
               end
            end
            ADDR: begin
               tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
               if (tmo_hit) begin
                  state_reg   <= DONE;
                  mem_req_reg <= 1'b0;
                  done_reg    <= 1'b1;
                  err_reg     <= 1'b1;
                  rdata_reg   <= 32'd0;
               end else if (mem_gnt_i) begin
                  state_reg   <= RESP;
                  mem_req_reg <= 1'b0;
               end
            end
            RESP: begin
               tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
               if (mem_rvalid_i) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
                  if (!we_reg) begin
                     rdata_reg <= load_next;
                  end
               end else if (tmo_hit) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
                  err_reg   <= 1'b1;
                  rdata_reg <= 32'd0;
               end
            end
            DONE: begin
               state_reg   <= IDLE;
               tmo_cnt_reg <= 16'd0;
            end
            default: begin
               state_reg   <= IDLE;
               mem_req_reg <= 1'b0;
            end
         endcase
      end
   end

   // Stall covers the accept cycle too; gating with rst forces it low while reset is asserted.
   assign hold_o = rst & (((state_reg == IDLE) & req_valid_i) |
                          (state_reg == ADDR) | (state_reg == RESP));

   assign done_o      = done_reg;
   assign err_o       = err_reg;
   assign rdata_o     = rdata_reg;
   assign mem_req_o   = mem_req_reg;
   assign mem_we_o    = we_reg;
   assign mem_addr_o  = addr_reg;
   assign mem_be_o    = be_reg;
   assign mem_wdata_o = wdata_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl (TIMEOUT_CYC=8). Inputs are driven and outputs
// sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_lsu_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid_i;
   logic        req_we_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        hold_o;
   logic        done_o;
   logic [31:0] rdata_o;
   logic        err_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;

   int n_cmp = 0;
   int n_bad = 0;

   lsu_mem_ctrl #(.TIMEOUT_CYC(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid_i),
      .req_we_i    (req_we_i),
      .funct3_i    (funct3_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .hold_o      (hold_o),
      .done_o      (done_o),
      .rdata_o     (rdata_o),
      .err_o       (err_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_be_o    (mem_be_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_gnt_i   (mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i (mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   // One access: gnt withheld for g ADDR cycles, rvalid the cycle after grant.
   // Called and returns at a falling edge with the DUT idle.
   task automatic txn(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                      input int g, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                      input logic [31:0] exp_wdata, input logic [31:0] exp_rdata);
      req_valid_i = 1'b1;
      req_we_i    = we;
      funct3_i    = f3;
      addr_i      = a;
      wdata_i     = wd;
      #1;
      chk({tag, ".hold_acc"}, hold_o, 1);
      @(negedge clk);
      req_valid_i = 1'b0;
      chk({tag, ".req"}, mem_req_o, 1);
      chk({tag, ".addr"}, mem_addr_o, exp_addr);
      chk({tag, ".be"}, mem_be_o, exp_be);
      chk({tag, ".we"}, mem_we_o, we);
      if (we) chk({tag, ".wdata"}, mem_wdata_o, exp_wdata);
      for (int i = 0; i < g; i++) begin
         @(negedge clk);
         chk({tag, ".req_wait"}, mem_req_o, 1);
         chk({tag, ".addr_wait"}, mem_addr_o, exp_addr);
         chk({tag, ".hold_wait"}, hold_o, 1);
      end
      mem_gnt_i = 1'b1;
      @(negedge clk);
      mem_gnt_i = 1'b0;
      chk({tag, ".req_resp"}, mem_req_o, 0);
      chk({tag, ".hold_resp"}, hold_o, 1);
      chk({tag, ".done_early"}, done_o, 0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rd;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      chk({tag, ".done"}, done_o, 1);
      chk({tag, ".err"}, err_o, 0);
      chk({tag, ".hold_done"}, hold_o, 0);
      chk({tag, ".rdata"}, rdata_o, exp_rdata);
      @(negedge clk);
      chk({tag, ".done_pulse"}, done_o, 0);
      $display("txn %s we=%0d addr=%h be=%h rdata_o=%h", tag, we, a, exp_be, rdata_o);
   endtask

   initial begin
      int cyc;
      rst          = 1'b0;
      req_valid_i  = 1'b0;
      req_we_i     = 1'b0;
      funct3_i     = 3'b000;
      addr_i       = 32'd0;
      wdata_i      = 32'd0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'd0;

      @(negedge clk);
      @(negedge clk);
      chk("rst.hold", hold_o, 0);
      chk("rst.done", done_o, 0);
      chk("rst.err", err_o, 0);
      chk("rst.req", mem_req_o, 0);
      chk("rst.rdata", rdata_o, 0);
      chk("rst.be", mem_be_o, 0);
      chk("rst.addr", mem_addr_o, 0);
      rst = 1'b1;
      @(negedge clk);
      $display("txn reset released");

      // Minimum latency case: done_o is checked three cycles after accept.
      txn("lw100", 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
      txn("lb103", 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
      txn("lbu103", 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0, 32'h100, 4'b1000, 32'h0, 32'h00000080);
      txn("sh102", 1, 3'b001, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 0, 32'h100, 4'b1100, 32'hABCDABCD, 32'h00000080);
      txn("lh102", 0, 3'b001, 32'h102, 32'h0, 32'h80011234, 1, 32'h100, 4'b1100, 32'h0, 32'hFFFF8001);
      txn("lhu000", 0, 3'b101, 32'h000, 32'h0, 32'h1234F00F, 0, 32'h000, 4'b0011, 32'h0, 32'h0000F00F);
      txn("sb101", 1, 3'b000, 32'h101, 32'h00000055, 32'h0, 0, 32'h100, 4'b0010, 32'h55555555, 32'h0000F00F);
      txn("sw104", 1, 3'b010, 32'h104, 32'hA5A55A5A, 32'h0, 0, 32'h104, 4'b1111, 32'hA5A55A5A, 32'h0000F00F);
      txn("ld011", 0, 3'b011, 32'h108, 32'h0, 32'h76543210, 2, 32'h108, 4'b1111, 32'h0, 32'h76543210);
      txn("lb101", 0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 0, 32'h100, 4'b0010, 32'h0, 32'h0000007F);

      // Misaligned word load.
`ifdef MISALIGN_TRAP_EN
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      funct3_i    = 3'b010;
      addr_i      = 32'h102;
      #1;
      chk("mis.hold_acc", hold_o, 1);
      @(negedge clk);
      req_valid_i = 1'b0;
      chk("mis.req", mem_req_o, 0);
      chk("mis.done", done_o, 1);
      chk("mis.err", err_o, 1);
      chk("mis.hold", hold_o, 0);
      chk("mis.rdata", rdata_o, 32'h0000007F);
      @(negedge clk);
      chk("mis.done_pulse", done_o, 0);
      chk("mis.req_after", mem_req_o, 0);
      $display("txn mis_trap addr=00000102 err_o pulsed");
`else
      txn("lw102", 0, 3'b010, 32'h102, 32'h0, 32'h11223344, 0, 32'h100, 4'b1111, 32'h0, 32'h11223344);
`endif

      // Grant withheld 5 cycles, then no response: timeout after 8 ADDR+RESP cycles.
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      funct3_i    = 3'b010;
      addr_i      = 32'h300;
      @(negedge clk);
      req_valid_i = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         chk("tmo.req_wait", mem_req_o, 1);
         chk("tmo.addr_wait", mem_addr_o, 32'h300);
         chk("tmo.hold_wait", hold_o, 1);
         @(negedge clk);
      end
      mem_gnt_i = 1'b1;
      @(negedge clk);
      mem_gnt_i = 1'b0;
      cyc = 7;
      while (!done_o && cyc < 30) begin
         chk("tmo.hold_resp", hold_o, 1);
         @(negedge clk);
         cyc++;
      end
      chk("tmo.latency", cyc, 9);
      chk("tmo.err", err_o, 1);
      chk("tmo.rdata", rdata_o, 0);
      chk("tmo.req", mem_req_o, 0);
      chk("tmo.hold", hold_o, 0);
      @(negedge clk);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hCAFEBABE;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      chk("late.done", done_o, 0);
      chk("late.rdata", rdata_o, 0);
      $display("txn timeout addr=00000300 cycles=%0d", cyc);

      // Reset asserted while waiting in RESP.
      txn("pre_rst", 0, 3'b010, 32'h0F0, 32'h0, 32'h0BADF00D, 0, 32'h0F0, 4'b1111, 32'h0, 32'h0BADF00D);
      req_valid_i = 1'b1;
      funct3_i    = 3'b010;
      addr_i      = 32'h400;
      @(negedge clk);
      req_valid_i = 1'b0;
      mem_gnt_i   = 1'b1;
      @(negedge clk);
      mem_gnt_i = 1'b0;
      chk("rresp.hold", hold_o, 1);
      rst = 1'b0;
      #1;
      chk("rresp.hold_rst", hold_o, 0);
      chk("rresp.req_rst", mem_req_o, 0);
      chk("rresp.rdata_rst", rdata_o, 0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h99999999;
      @(negedge clk);
      chk("rresp.done_rst", done_o, 0);
      rst          = 1'b1;
      mem_rvalid_i = 1'b0;
      @(negedge clk);
      chk("rresp.done_after", done_o, 0);
      chk("rresp.hold_after", hold_o, 0);
      $display("txn reset_in_resp aborted");
      txn("post_rst", 0, 3'b010, 32'h500, 32'h0, 32'h13572468, 0, 32'h500, 4'b1111, 32'h0, 32'h13572468);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Absolute time guard in case a handshake never completes.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "bench watchdog");
   end

endmodule
